// File: rtl/qmax_writer_if.sv
// rtl/qmax_writer_if.sv - update request handshake between Q-update datapath and qmax_writer
interface qmax_writer_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] state;
  logic [DATA_WIDTH-1:0] qval;

  modport master (output valid, output state, output qval, input ready);
  modport slave  (input valid, input state, input qval, output ready);
endinterface

// File: rtl/qmax_writer.sv
// rtl/qmax_writer.sv - read-compare-write controller for the per-state Q-max table
module qmax_writer #(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = 32'h8000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  qmax_writer_if.slave          upd,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_clear_done,
  output logic                  o_changed,
  output logic                  o_read_en,
  output logic [ADDR_WIDTH-1:0] o_addr_r,
  input  logic [DATA_WIDTH-1:0] i_tbl_data,
  output logic                  o_write_en,
  output logic [ADDR_WIDTH-1:0] o_addr_w,
  output logic [DATA_WIDTH-1:0] o_data
);

  typedef enum logic [1:0] {IDLE, RUN, CLR_WAIT, CLEAR} fsm_t;

  fsm_t fsm_q, fsm_d;

  // Stage C: accepted request waiting for its table read data
  logic                  c_valid;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_qval;

  // Stage W: improving update being written this cycle
  logic                  w_valid;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;

  // History: whatever was written to the table in the previous cycle
  logic                  h_valid;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_data;

  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic                  busy_q;
  logic                  done_q;

  logic                  accepting;
  logic                  accept;
  logic                  clearing;
  logic                  clr_last;
  logic [DATA_WIDTH-1:0] cur;
  logic                  c_wr;

  assign accepting = (fsm_q == IDLE) || (fsm_q == RUN);
  assign upd.ready = accepting && !i_clear;
  assign accept    = upd.valid && upd.ready;
  assign clearing  = (fsm_q == CLEAR);
  assign clr_last  = (clr_cnt == ADDR_WIDTH'(DEPTH - 1));

  // Current stored maximum for stage C; the in-flight write beats the history register
  always_comb begin
    cur = i_tbl_data;
    if (h_valid && (h_addr == c_addr)) cur = h_data;
    if (w_valid && (w_addr == c_addr)) cur = w_data;
  end

  assign c_wr = c_valid && ($signed(c_qval) > $signed(cur));

  // Next-state logic: accept/run, wait for pipeline drain, then sweep
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE, RUN: begin
        if (i_clear)             fsm_d = CLR_WAIT;
        else if (accept || c_wr) fsm_d = RUN;
        else                     fsm_d = IDLE;
      end
      CLR_WAIT: if (!c_valid && !w_valid) fsm_d = CLEAR;
      CLEAR:    if (clr_last) fsm_d = IDLE;
      default:  fsm_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) fsm_q <= IDLE;
    else          fsm_q <= fsm_d;
  end

  // Update pipeline: capture into C on accept, register improving writes into W
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      c_valid <= 1'b0;
      c_addr  <= '0;
      c_qval  <= '0;
      w_valid <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
    end else begin
      c_valid <= accept;
      if (accept) begin
        c_addr <= upd.state;
        c_qval <= upd.qval;
      end
      w_valid <= c_wr;
      if (c_wr) begin
        w_addr <= c_addr;
        w_data <= c_qval;
      end
    end
  end

  // History tracks every table write, sweep writes included, so it always mirrors memory
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_valid <= 1'b0;
      h_addr  <= '0;
      h_data  <= '0;
    end else begin
      h_valid <= o_write_en;
      h_addr  <= o_addr_w;
      h_data  <= o_data;
    end
  end

  // Sweep address counter, busy flag and completion pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      clr_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      clr_cnt <= clearing ? clr_cnt + 1'b1 : '0;
      if (accepting && i_clear)    busy_q <= 1'b1;
      else if (clearing && clr_last) busy_q <= 1'b0;
      done_q <= clearing && clr_last;
    end
  end

  assign o_busy       = busy_q;
  assign o_clear_done = done_q;
  assign o_changed    = w_valid;
  assign o_read_en    = accept;
  assign o_addr_r     = upd.state;
  assign o_write_en   = w_valid || clearing;
  assign o_addr_w     = clearing ? clr_cnt : w_addr;
  assign o_data       = clearing ? INIT_VAL : w_data;

endmodule
